pc_unit: RTL

// Fetch-stage program counter for the pipelined MIPS core: holds PC_F and selects the next PC

---
 rtl/pc_defs.sv | 17 +
 rtl/npc_calc.sv | 62 ++++++
 rtl/pc_unit.sv | 74 +++++++
 3 files changed

// File: rtl/pc_defs.sv
// Shared definitions for the fetch-stage program counter: next-PC select
// encodings and the default reset, exception and instruction-memory addresses.
package pc_defs;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'b000,
    NPC_BR   = 3'b001,
    NPC_J    = 3'b010,
    NPC_JR   = 3'b011,
    NPC_ERET = 3'b100
  } npc_op_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: target arithmetic plus the priority mux
// (exception, stall, eret, jr, j, taken branch, sequential).
module npc_calc #(
  parameter int unsigned      PC_W    = 32,
  parameter logic [PC_W-1:0]  EXC_VEC = PC_W'(pc_defs::EXC_VEC)
) (
  input  logic [PC_W-1:0] pc_f,
  input  logic            stall,
  input  logic            exc_req,
  input  logic [2:0]      npc_op,
  input  logic            br_taken,
  input  logic [PC_W-1:0] pc_d,
  input  logic [15:0]     imm16,
  input  logic [25:0]     addr26,
  input  logic [PC_W-1:0] ra,
  input  logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] npc,
  output logic            redirect
);
  import pc_defs::*;

  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;

  assign br_tgt = pc_d + PC_W'(4) + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {pc_d[PC_W-1:28], addr26, 2'b00};

  always_comb begin
    npc      = pc_f + PC_W'(4);
    redirect = 1'b0;
    if (exc_req) begin
      npc      = EXC_VEC;
      redirect = 1'b1;
    end else if (stall) begin
      // Hold: the D instruction re-resolves once the stall clears.
      npc = pc_f;
    end else begin
      case (npc_op_e'(npc_op))
        NPC_ERET: begin
          npc      = epc;
          redirect = 1'b1;
        end
        NPC_JR: begin
          npc      = ra;
          redirect = 1'b1;
        end
        NPC_J: begin
          npc      = j_tgt;
          redirect = 1'b1;
        end
        NPC_BR: begin
          if (br_taken) begin
            npc      = br_tgt;
            redirect = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: registered PC_F with stall, exception/eret
// redirection, D-stage flush, fetch-address fault and a saturating redirect count.
module pc_unit #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(pc_defs::RESET_PC),
  parameter logic [PC_W-1:0] EXC_VEC    = PC_W'(pc_defs::EXC_VEC),
  parameter logic [PC_W-1:0] IM_BASE    = PC_W'(pc_defs::IM_BASE),
  parameter int unsigned     IM_WORDS   = 4096,
  parameter bit              DELAY_SLOT = 1'b1,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       NPCOp_D,
  input  logic             br_taken_D,
  input  logic [PC_W-1:0]  PC_D,
  input  logic [15:0]      imm16_D,
  input  logic [25:0]      addr26_D,
  input  logic [PC_W-1:0]  RA_D,
  input  logic [PC_W-1:0]  EPC,
  input  logic             exc_req,
  output logic [PC_W-1:0]  PC_F,
  output logic             fault_F,
  output logic             flush_D,
  output logic             redirect,
  output logic [CNT_W-1:0] redirect_cnt
);
  import pc_defs::*;

  // One bit wider so IM_BASE + 4*IM_WORDS cannot overflow the compare.
  localparam logic [PC_W:0] IM_END = (PC_W+1)'(IM_BASE) + (PC_W+1)'(4 * IM_WORDS);

  logic [PC_W-1:0] npc;
  logic            is_eret;

  npc_calc #(
    .PC_W    (PC_W),
    .EXC_VEC (EXC_VEC)
  ) u_npc_calc (
    .pc_f     (PC_F),
    .stall    (stall),
    .exc_req  (exc_req),
    .npc_op   (NPCOp_D),
    .br_taken (br_taken_D),
    .pc_d     (PC_D),
    .imm16    (imm16_D),
    .addr26   (addr26_D),
    .ra       (RA_D),
    .epc      (EPC),
    .npc      (npc),
    .redirect (redirect)
  );

  assign is_eret = (NPCOp_D == NPC_ERET);

  // eret never has a delay slot, regardless of DELAY_SLOT.
  assign flush_D = exc_req | (is_eret & ~stall) | (~DELAY_SLOT & redirect & ~stall);

  assign fault_F = (|PC_F[1:0]) | (PC_F < IM_BASE) | ({1'b0, PC_F} >= IM_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_F         <= RESET_PC;
      redirect_cnt <= '0;
    end else begin
      PC_F <= npc;
      if (redirect && (redirect_cnt != {CNT_W{1'b1}})) begin
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
    end
  end

endmodule
